// File: rtl/oram_path_writeback_pkg.sv
// Shared types, sizes and path arithmetic for the ORAM path write-back engine.
package oram_path_writeback_pkg;
    localparam int D        = 6;
    localparam int A        = 8;
    localparam int K        = 3;
    localparam int STASH_SZ = 16;

    localparam int TW     = 1 + (D - 1) + D + 8 * A;
    localparam int CNT_W  = $clog2(STASH_SZ + 1);
    localparam int IDX_W  = $clog2(STASH_SZ);
    localparam int LVL_W  = $clog2(D);
    localparam int SLOT_W = $clog2(K + 1);

    typedef struct packed {
        logic           valid;
        logic [D-2:0]   pos;
        logic [D-1:0]   bnum;
        logic [8*A-1:0] val;
    } oram_tuple_p;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } wb_state_e;

    // Walk from the root, taking leaf bit i to choose the child at level i+1.
    function automatic logic [D-1:0] path_node(input logic [D-2:0] leaf, input int level);
        logic [D-1:0] node;
        node = D'(1);
        for (int i = 0; i < D - 1; i++) begin
            if (i < level) node = {node[D-2:0], leaf[i]};
        end
        return node;
    endfunction
endpackage

// File: rtl/oram_path_writeback_if.sv
// Stash push, eviction command and tree-memory write bus of the write-back engine.
interface oram_path_writeback_if;
    import oram_path_writeback_pkg::*;

    logic             in_valid;
    logic             in_ready;
    oram_tuple_p      in_tuple;
    logic             start;
    logic [D-2:0]     leaf;
    logic             busy;
    logic             done;
    logic             wr_valid;
    logic             wr_ready;
    logic [D-1:0]     wr_addr;
    logic [K*TW-1:0]  wr_bucket;
    logic [CNT_W-1:0] stash_count;

    modport master (
        output in_valid, in_tuple, start, leaf, wr_ready,
        input  in_ready, busy, done, wr_valid, wr_addr, wr_bucket, stash_count
    );

    modport slave (
        input  in_valid, in_tuple, start, leaf, wr_ready,
        output in_ready, busy, done, wr_valid, wr_addr, wr_bucket, stash_count
    );
endinterface

// File: rtl/oram_path_writeback_stash.sv
// Stash storage: entry array with occupancy, lowest-free push, per-index clear and count.
module oram_stash
    import oram_path_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_en,
    input  oram_tuple_p      push_tuple,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output oram_tuple_p      rd_tuple,
    output logic             rd_occ,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    oram_tuple_p         entries_q [STASH_SZ];
    oram_tuple_p         entries_d [STASH_SZ];
    logic [STASH_SZ-1:0] occ_q, occ_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    free_idx;
    logic                push_fire, clr_fire;

    assign full     = &occ_q;
    assign rd_tuple = entries_q[rd_idx];
    assign rd_occ   = occ_q[rd_idx];
    assign count    = count_q;

    always_comb begin
        free_idx = '0;
        for (int i = STASH_SZ - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = IDX_W'(i);
        end
        push_fire = push_en && !full;
        clr_fire  = clr_en && occ_q[clr_idx];
        entries_d = entries_q;
        occ_d     = occ_q;
        if (push_fire) begin
            entries_d[free_idx] = push_tuple;
            occ_d[free_idx]     = 1'b1;
        end
        if (clr_fire) occ_d[clr_idx] = 1'b0;
        count_d = count_q + CNT_W'(push_fire) - CNT_W'(clr_fire);
    end

    // Entry payloads need no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
        if (!rst_n) begin
            occ_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/oram_path_writeback.sv
// Path eviction: writes the stash back along one tree path, deepest bucket first,
// greedily placing each tuple at the deepest level its position allows.
module oram_path_writeback
    import oram_path_writeback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    oram_path_writeback_if.slave bus
);
    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(D - 1);

    wb_state_e        state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt;
    logic [K*TW-1:0]  bucket_q, bucket_d;
    logic [D-2:0]     leaf_q, leaf_d;
    logic             wr_valid_q, wr_valid_d;
    logic [D-1:0]     wr_addr_q, wr_addr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    oram_tuple_p      rd_tuple;
    logic             rd_occ, full, clr_en, eligible, push_en;
    logic [D-2:0]     lvl_mask;
    logic [CNT_W-1:0] count;

    assign bus.in_ready    = (state_q == ST_IDLE) && !full && !bus.start;
    assign push_en         = bus.in_valid && bus.in_ready;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_bucket   = bucket_q;
    assign bus.stash_count = count;

    oram_stash u_stash (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_en    (push_en),
        .push_tuple (bus.in_tuple),
        .clr_en     (clr_en),
        .clr_idx    (idx_q),
        .rd_idx     (idx_q),
        .rd_tuple   (rd_tuple),
        .rd_occ     (rd_occ),
        .full       (full),
        .count      (count)
    );

    // Only the low L position bits must agree with the path at level L.
    always_comb begin
        for (int i = 0; i < D - 1; i++) lvl_mask[i] = (i < int'(level_q));
        eligible = (state_q == ST_SCAN) && rd_occ && rd_tuple.valid &&
                   (((rd_tuple.pos ^ leaf_q) & lvl_mask) == '0);
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        slot_nxt   = slot_q;
        bucket_d   = bucket_q;
        leaf_d     = leaf_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        done_d     = 1'b0;
        clr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_SCAN;
                    level_d  = LVL_TOP;
                    idx_d    = '0;
                    slot_d   = '0;
                    bucket_d = '0;
                    leaf_d   = bus.leaf;
                end
            end
            ST_SCAN: begin
                if (eligible) begin
                    clr_en = 1'b1;
                    for (int j = 0; j < K; j++) begin
                        if (SLOT_W'(j) == slot_q) bucket_d[j*TW +: TW] = rd_tuple;
                    end
                    slot_nxt = slot_q + SLOT_W'(1);
                end
                slot_d = slot_nxt;
                if (slot_nxt == SLOT_W'(K) || idx_q == IDX_W'(STASH_SZ - 1)) begin
                    state_d    = ST_WRITE;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = path_node(leaf_q, int'(level_q)) - D'(1);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_WRITE: begin
                if (bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (level_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_SCAN;
                        level_d  = level_q - LVL_W'(1);
                        idx_d    = '0;
                        slot_d   = '0;
                        bucket_d = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            idx_q      <= '0;
            slot_q     <= '0;
            bucket_q   <= '0;
            leaf_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            bucket_q   <= bucket_d;
            leaf_q     <= leaf_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_oram_path_writeback.sv
// Randomized bench for oram_path_writeback against a path-placement reference model.
module tb_oram_path_writeback;
    import oram_path_writeback_pkg::*;

    localparam int PW = D - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    oram_path_writeback_if bus();

    oram_path_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    oram_tuple_p     mtup [STASH_SZ];
    bit              mocc [STASH_SZ];
    int              mcount;
    logic [D-1:0]    exp_addr [D];
    logic [K*TW-1:0] exp_bkt [D];
    logic [D-1:0]    obs_addr [D];
    int              errors, checks;

    function automatic oram_tuple_p rand_tuple(input bit force_valid);
        oram_tuple_p t;
        t.valid = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        t.pos   = PW'($urandom);
        t.bnum  = D'($urandom);
        t.val   = {$urandom, $urandom};
        return t;
    endfunction

    // Level L bucket sits at node 2^L + (first L leaf bits read root-first); a tuple
    // fits there when pos and leaf agree modulo 2^L.
    task automatic model_evict(input logic [D-2:0] lf);
        for (int w = 0; w < D; w++) begin
            int lvl, node, n;
            lvl  = D - 1 - w;
            node = 1 << lvl;
            for (int i = 0; i < lvl; i++) node += int'(lf[i]) << (lvl - 1 - i);
            exp_addr[w] = D'(node - 1);
            exp_bkt[w]  = '0;
            n = 0;
            for (int e = 0; e < STASH_SZ; e++) begin
                if (mocc[e] && mtup[e].valid && n < K &&
                    (int'(mtup[e].pos) % (1 << lvl)) == (int'(lf) % (1 << lvl))) begin
                    exp_bkt[w][n*TW +: TW] = mtup[e];
                    mocc[e] = 1'b0;
                    mcount--;
                    n++;
                end
            end
        end
    endtask

    task automatic push(input oram_tuple_p t);
        bit exp_rdy;
        int f;
        bus.in_valid = 1'b1;
        bus.in_tuple = t;
        #1;
        exp_rdy = (mcount < STASH_SZ);
        checks++;
        if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL push_ready got=%b exp=%b", bus.in_ready, exp_rdy);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (exp_rdy) begin
            f = 0;
            for (int e = STASH_SZ - 1; e >= 0; e--) if (!mocc[e]) f = e;
            mtup[f] = t;
            mocc[f] = 1'b1;
            mcount++;
        end
        checks++;
        if (bus.stash_count !== CNT_W'(mcount)) begin
            errors++;
            $display("FAIL push_count got=%0d exp=%0d", bus.stash_count, mcount);
        end
    endtask

    task automatic evict(input logic [D-2:0] lf, input int stall, input bit with_push);
        int nwr, cyc, stalled;
        bit seen_done;
        logic [D-1:0]    hold_addr;
        logic [K*TW-1:0] hold_bkt;
        model_evict(lf);
        bus.start    = 1'b1;
        bus.leaf     = lf;
        bus.wr_ready = 1'b0;
        if (with_push) begin
            bus.in_valid = 1'b1;
            bus.in_tuple = rand_tuple(1'b1);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL push_with_start in_ready=%b exp=0", bus.in_ready);
            end
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%b exp=1", bus.busy);
        end
        nwr = 0; cyc = 0; stalled = 0; seen_done = 1'b0;
        hold_addr = '0; hold_bkt = '0;
        while (!seen_done && cyc < 400) begin
            if (cyc == 3) begin
                bus.start = 1'b1;
                bus.leaf  = ~lf;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                checks++;
                if (nwr != D || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_point writes=%0d busy=%b exp writes=%0d busy=1", nwr, bus.busy, D);
                end
            end else if (bus.wr_valid) begin
                if (nwr == 0 && stalled < stall) begin
                    if (stalled == 0) begin
                        hold_addr = bus.wr_addr;
                        hold_bkt  = bus.wr_bucket;
                    end else begin
                        checks++;
                        if (bus.wr_addr !== hold_addr || bus.wr_bucket !== hold_bkt) begin
                            errors++;
                            $display("FAIL stall_stable addr=%0d exp=%0d", bus.wr_addr, hold_addr);
                        end
                    end
                    bus.wr_ready = 1'b0;
                    stalled++;
                end else begin
                    if (nwr < D) begin
                        obs_addr[nwr] = bus.wr_addr;
                        checks++;
                        if (bus.wr_addr !== exp_addr[nwr]) begin
                            errors++;
                            $display("FAIL wr_addr[%0d] got=%0d exp=%0d", nwr, bus.wr_addr, exp_addr[nwr]);
                        end
                        checks++;
                        if (bus.wr_bucket !== exp_bkt[nwr]) begin
                            errors++;
                            $display("FAIL wr_bucket[%0d] got=%h exp=%h", nwr, bus.wr_bucket, exp_bkt[nwr]);
                        end
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write addr=%0d exp none", bus.wr_addr);
                    end
                    bus.wr_ready = 1'b1;
                    nwr++;
                end
            end else begin
                bus.wr_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.wr_ready = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL evict_timeout writes=%0d exp done after %0d", nwr, D);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.stash_count !== CNT_W'(mcount)) begin
            errors++;
            $display("FAIL residue_count got=%0d exp=%0d", bus.stash_count, mcount);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.wr_valid !== 1'b0 || bus.wr_addr !== '0 || bus.wr_bucket !== '0 ||
            bus.stash_count !== '0) begin
            errors++;
            $display("FAIL reset_values rdy=%b busy=%b done=%b wv=%b addr=%0d cnt=%0d exp 1 0 0 0 0 0",
                     bus.in_ready, bus.busy, bus.done, bus.wr_valid, bus.wr_addr, bus.stash_count);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d wr_valid=%b busy=%b exp 0 0", c, bus.wr_valid, bus.busy);
            end
        end
    endtask

    task automatic test_single;
        oram_tuple_p t;
        int ref_addr [D] = '{57, 28, 13, 6, 2, 0};
        t = rand_tuple(1'b1);
        t.pos  = 5'b01011;
        t.bnum = 6'd7;
        push(t);
        evict(5'b01011, 0, 1'b0);
        for (int w = 0; w < D; w++) begin
            checks++;
            if (obs_addr[w] !== D'(ref_addr[w])) begin
                errors++;
                $display("FAIL single_path[%0d] got=%0d exp=%0d", w, obs_addr[w], ref_addr[w]);
            end
        end
    endtask

    task automatic test_fill_pos0;
        oram_tuple_p t;
        for (int i = 0; i < 4; i++) begin
            t = rand_tuple(1'b1);
            t.pos = '0;
            push(t);
        end
        evict('0, 0, 1'b0);
        checks++;
        if (obs_addr[0] !== D'(31) || obs_addr[D-1] !== D'(0)) begin
            errors++;
            $display("FAIL pos0_ends got=%0d,%0d exp=31,0", obs_addr[0], obs_addr[D-1]);
        end
    endtask

    task automatic test_root_only;
        oram_tuple_p t;
        t = rand_tuple(1'b1);
        t.pos = PW'(1);
        push(t);
        evict('0, 0, 1'b0);
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) push(rand_tuple(1'b1));
        evict(PW'($urandom), 4, 1'b0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) push(rand_tuple(1'b0));
            evict(PW'($urandom), $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_full;
        while (mcount < STASH_SZ) push(rand_tuple(1'b0));
        checks++;
        if (bus.in_ready !== 1'b0 || bus.stash_count !== CNT_W'(STASH_SZ)) begin
            errors++;
            $display("FAIL full_flag in_ready=%b cnt=%0d exp 0 %0d", bus.in_ready, bus.stash_count, STASH_SZ);
        end
        push(rand_tuple(1'b1));
        evict(PW'($urandom), 0, 1'b0);
        evict('0, 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int bad;
        for (int i = 0; i < 3; i++) push(rand_tuple(1'b1));
        bus.start = 1'b1;
        bus.leaf  = PW'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got=%b exp=1", bus.busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < STASH_SZ; e++) mocc[e] = 1'b0;
        mcount = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.stash_count !== '0 || bus.wr_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b cnt=%0d wv=%b done=%b exp 0 0 0 0",
                     bus.busy, bus.stash_count, bus.wr_valid, bus.done);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.wr_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_quiet bad_cycles=%0d in_ready=%b exp 0 1", bad, bus.in_ready);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mcount = 0;
        for (int e = 0; e < STASH_SZ; e++) mocc[e] = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_tuple = '0;
        bus.start    = 1'b0;
        bus.leaf     = '0;
        bus.wr_ready = 1'b0;
        test_reset;
        test_single;
        test_fill_pos0;
        test_root_only;
        test_stall;
        test_random;
        test_full;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
